// File: rtl/moving_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moving_sum_pkg
// Description : Shared definitions for the moving-window summer: FSM state
//               encoding, the output-width helper and default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package moving_sum_pkg;

    // Default geometry: 8-bit samples, 8-sample window.
    localparam int c_dw_default  = 8;
    localparam int c_win_default = 8;

    // State encodings, kept as explicit-width constants so older code that
    // compares against raw codes keeps working.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;
    localparam logic [1:0] c_st_out  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,  // waiting for a sample or a flush
        ST_RD   = c_st_rd,    // reading the oldest sample from RAM
        ST_WR   = c_st_wr,    // overwriting it and updating the sum
        ST_OUT  = c_st_out    // presenting the sum downstream
    } state_e;

    // Sum width that holds WIN * (2**DW - 1) without overflow.
    function automatic int calc_ow(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

endpackage : moving_sum_pkg
`default_nettype wire

// File: rtl/moving_sum_mem.sv
`default_nettype none
// ============================================================================
// Module      : moving_sum_mem
// Description : Sliding-window summer. Each accepted sample is written into an
//               external single-port synchronous RAM used as a circular buffer
//               of WIN words; the running sum of the newest min(N, WIN)
//               samples is emitted on a busy/vld output stream.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               din_vld    - input sample valid
//               din_data   - input sample [DW]
//               din_busy   - cannot accept a sample this cycle
//               flush      - clear the window (honoured only while idle)
//               dout_busy  - downstream stall
//               dout_vld   - dout_data valid
//               dout_data  - window sum [OW]
//               mem_REQ0   - RAM access request
//               mem_WE0    - RAM write enable
//               mem_A0     - RAM address [AW]
//               mem_DIN0   - RAM write data [DW]
//               mem_DOUT0  - RAM read data, one cycle after a read request
// Revision    : 1.0 - initial release
// ============================================================================
module moving_sum_mem
    import moving_sum_pkg::*;
#(
    parameter int DW  = c_dw_default,
    parameter int WIN = c_win_default,
    parameter int AW  = $clog2(WIN),
    parameter int OW  = calc_ow(DW, WIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_vld,
    input  logic [DW-1:0] din_data,
    output logic          din_busy,
    input  logic          flush,
    input  logic          dout_busy,
    output logic          dout_vld,
    output logic [OW-1:0] dout_data,
    output logic          mem_REQ0,
    output logic          mem_WE0,
    output logic [AW-1:0] mem_A0,
    output logic [DW-1:0] mem_DIN0,
    input  logic [DW-1:0] mem_DOUT0
);

    localparam logic [AW:0]   c_win  = (AW+1)'(WIN);
    localparam logic [AW-1:0] c_last = AW'(WIN - 1);

    state_e        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_count;
    logic [OW-1:0] r_sum;
    logic [DW-1:0] r_x;
    logic [OW-1:0] r_dout;

    logic [DW-1:0] w_old;
    logic [OW-1:0] w_sum_next;

    // Until the window has filled, the word at r_ptr was never written in
    // this window, so its RAM contents must not be subtracted.
    assign w_old      = (r_count == c_win) ? mem_DOUT0 : '0;
    // sum >= old at all times, so the subtraction never wraps.
    assign w_sum_next = r_sum + OW'(r_x) - OW'(w_old);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_x     <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // flush has priority over an offered sample
                    if (flush) begin
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_sum   <= '0;
                    end else if (din_vld) begin
                        r_x     <= din_data;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_sum   <= w_sum_next;
                    r_dout  <= w_sum_next;
                    r_ptr   <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
                    if (r_count != c_win) begin
                        r_count <= r_count + 1'b1;
                    end
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (!dout_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; only din_busy looks at an input.
    assign din_busy  = (r_state == ST_IDLE) ? flush : 1'b1;
    assign dout_vld  = (r_state == ST_OUT);
    assign dout_data = r_dout;
    assign mem_REQ0  = (r_state == ST_RD) || (r_state == ST_WR);
    assign mem_WE0   = (r_state == ST_WR);
    assign mem_A0    = mem_REQ0 ? r_ptr : '0;
    assign mem_DIN0  = (r_state == ST_WR) ? r_x : '0;

endmodule : moving_sum_mem
`default_nettype wire
